// File: rtl/mult_ctrl_pkg.sv
// Shared widths, step counts and FSM state encoding for the sequential multiplier.
package mult_ctrl_pkg;

    localparam int OP_W      = 4;
    localparam int PROD_W    = 8;
    localparam int BCD_W     = 12;
    localparam int MUL_STEPS = 4;
    localparam int DAB_STEPS = 8;

    // Last value of the step counter in each iterative phase
    localparam logic [2:0] MUL_LAST = 3'(MUL_STEPS - 1);
    localparam logic [2:0] DAB_LAST = 3'(DAB_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DAB,
        DONE
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle of the sequential multiplier; slave is the controller side.
interface mult_seq_ctrl_if;
    import mult_ctrl_pkg::*;

    logic              start;
    logic [OP_W-1:0]   A1;
    logic [OP_W-1:0]   A2;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;
    logic [BCD_W-1:0]  BCD;
    logic [6:0]        Seg1;
    logic [6:0]        Seg2;
    logic [6:0]        Seg3;

    modport master (
        output start, A1, A2,
        input  busy, done, product, BCD, Seg1, Seg2, Seg3
    );

    modport slave (
        input  start, A1, A2,
        output busy, done, product, BCD, Seg1, Seg2, Seg3
    );

endinterface

// File: rtl/BCD7Segments.sv
// Seven-segment decoder for one BCD digit; bit order {a,b,c,d,e,f,g}, active high, blank above 9.
module BCD7Segments (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit-to-segment lookup
    always_comb begin
        o_seg = 7'b0000000;
        case (i_bcd)
            4'd0: o_seg = 7'b1111110;
            4'd1: o_seg = 7'b0110000;
            4'd2: o_seg = 7'b1101101;
            4'd3: o_seg = 7'b1111001;
            4'd4: o_seg = 7'b0110011;
            4'd5: o_seg = 7'b1011011;
            4'd6: o_seg = 7'b1011111;
            4'd7: o_seg = 7'b1110000;
            4'd8: o_seg = 7'b1111111;
            4'd9: o_seg = 7'b1111011;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/mult_seq_ctrl_dabble_step.sv
// One double-dabble iteration on {dab, bin}: add 3 to every BCD nibble >= 5, then shift left.
module dabble_step
    import mult_ctrl_pkg::*;
(
    input  logic [BCD_W+PROD_W-1:0] i_pair,
    output logic [BCD_W+PROD_W-1:0] o_pair
);

    logic [BCD_W+PROD_W-1:0] w_adj;

    // Nibble correction followed by the one-bit shift
    always_comb begin
        w_adj = i_pair;
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_adj[PROD_W + 4*i +: 4] >= 4'd5)
                w_adj[PROD_W + 4*i +: 4] = w_adj[PROD_W + 4*i +: 4] + 4'd3;
        end
        o_pair = {w_adj[BCD_W+PROD_W-2:0], 1'b0};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 4x4 multiplier: shift-and-add product, double-dabble BCD, seven-segment decode.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mult_seq_ctrl_if.slave  bus
);

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_cnt;
    logic [PROD_W-1:0]       r_a_sh;
    logic [OP_W-1:0]         r_b_sh;
    logic [PROD_W-1:0]       r_acc;
    logic [PROD_W-1:0]       r_bin;
    logic [BCD_W-1:0]        r_dab;
    logic [PROD_W-1:0]       r_product;
    logic [BCD_W-1:0]        r_bcd;
    logic [PROD_W-1:0]       w_acc_next;
    logic [BCD_W+PROD_W-1:0] w_dab_pair;

    assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

    dabble_step u_dabble (
        .i_pair (  {r_dab, r_bin}),
        .o_pair (w_dab_pair)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = MUL;
            MUL:     if (r_cnt == MUL_LAST) w_next = DAB;
            DAB:     if (r_cnt == DAB_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
    end

    // Operand capture, multiply/dabble iterations and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_acc     <= '0;
            r_bin     <= '0;
            r_dab     <= '0;
            r_product <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a_sh <= {4'b0000, bus.A1};
                        r_b_sh <= bus.A2;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    if (r_cnt == MUL_LAST) begin
                        // bin takes the post-add value of the last step
                        r_bin <= w_acc_next;
                        r_dab <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                DAB: begin
                    {r_dab, r_bin} <= w_dab_pair;
                    if (r_cnt == DAB_LAST) begin
                        // acc is untouched during DAB and still holds the binary product
                        r_product <= r_acc;
                        r_bcd     <= w_dab_pair[BCD_W+PROD_W-1:PROD_W];
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product = r_product;
    assign bus.BCD     = r_bcd;

    BCD7Segments u_seg1 (.i_bcd(r_bcd[11:8]), .o_seg(bus.Seg1));
    BCD7Segments u_seg2 (.i_bcd(r_bcd[7:4]),  .o_seg(bus.Seg2));
    BCD7Segments u_seg3 (.i_bcd(r_bcd[3:0]),  .o_seg(bus.Seg3));

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: stimulus pushes expected results, a monitor checks each done.
module tb_mult_seq_ctrl;

    typedef struct {
        logic [7:0]  p;
        logic [11:0] bcd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [7:0]  prev_p   = 8'd0;
    logic [11:0] prev_bcd = 12'h000;

    mult_seq_ctrl_if bus ();

    mult_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Independent segment table, {a..g} active high
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int p;
        p = a * b;
        e.p   = 8'(p);
        e.bcd = {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(bus.product), 32'(e.p));
                check("bcd",     32'(bus.BCD),     32'(e.bcd));
                check("seg1",    32'(bus.Seg1),    32'(seg_of(e.bcd[11:8])));
                check("seg2",    32'(bus.Seg2),    32'(seg_of(e.bcd[7:4])));
                check("seg3",    32'(bus.Seg3),    32'(seg_of(e.bcd[3:0])));
            end
        end
    end

    // Issue one operation; returns with the DUT back in IDLE, #1 after the edge
    task automatic run_op(input int a, input int b, input bit timing);
        exp_t e;
        int lat, busy_cnt, first_done;
        e = model(a, b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A1    = 4'(a);
        bus.A2    = 4'(b);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.A1     = 4'(~a);
        bus.A2     = 4'(~b);
        busy_cnt   = (bus.busy === 1'b1) ? 1 : 0;
        first_done = -1;
        lat        = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1 && first_done < 0) first_done = lat;
            if (timing && lat == 6) begin
                check("hold_product_during_run", 32'(bus.product), 32'(prev_p));
                check("hold_bcd_during_run",     32'(bus.BCD),     32'(prev_bcd));
            end
            if (bus.busy !== 1'b1) break;
        end
        if (bus.busy === 1'b1) check("idle_timeout", 32'd1, 32'd0);
        if (timing) begin
            check("done_latency", 32'(first_done), 32'd12);
            check("busy_cycles",  32'(busy_cnt),   32'd13);
        end
        prev_p   = e.p;
        prev_bcd = e.bcd;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy === 1'b1) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.A1    = 4'd0;
        bus.A2    = 4'd0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_bcd",     32'(bus.BCD),     32'h000);
        check("rst_seg1",    32'(bus.Seg1),    32'(seg_of(4'd0)));
        check("rst_seg2",    32'(bus.Seg2),    32'(seg_of(4'd0)));
        check("rst_seg3",    32'(bus.Seg3),    32'(seg_of(4'd0)));
        rst = 1'b0;

        // Maximum operands, then a mid-range and a zero product
        run_op(15, 15, 1'b1);
        run_op(7, 6, 1'b1);
        run_op(0, 9, 1'b1);

        // start re-asserted with new operands during MUL and DAB is ignored
        sb.push_back(model(7, 6));
        @(negedge clk);
        bus.start = 1'b1;
        bus.A1    = 4'd7;
        bus.A2    = 4'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A1    = 4'd15;
        bus.A2    = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        check("ignored_start_product", 32'(bus.product), 32'd42);
        check("ignored_start_busy",    32'(bus.busy),    32'd0);

        // Reset sampled on the third DAB edge aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.A1    = 4'd9;
        bus.A2    = 4'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",    32'(bus.busy),    32'd0);
        check("abort_done",    32'(bus.done),    32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        check("abort_bcd",     32'(bus.BCD),     32'h000);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(bus.busy), 32'd0);
        prev_p   = 8'd0;
        prev_bcd = 12'h000;

        // Back-to-back: second start on the first IDLE cycle
        run_op(3, 5, 1'b1);
        run_op(12, 11, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_product", 32'(bus.product), 32'd132);
        check("hold_bcd",     32'(bus.BCD),     32'h132);

        // All operand pairs
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(a, b, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
